// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, types and small helpers.
package aes_pkg;

  // AES-128 only: ten rounds, eleven round keys.
  localparam int NR = 10;

  // Round constants, 0-based: RCON[0] is used for round key 1.
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Schedule controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } ks_state_t;

  // Round key as four 32-bit words; element 0 is the most significant word.
  typedef logic [0:3][31:0] rk_words_t;

  // Cyclic left rotation by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round-constant lookup that returns zero for indices outside the table,
  // so the mux stays well defined in states where the index is meaningless.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (idx == 4'(i)) begin
        b = RCON[i];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four S-boxes, each the affine map of the
// multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1.
module aes_subword (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // GF(2^8) multiply by shift-and-add with xtime reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (bits 1..7 of the exponent set); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign o_word[gi*8 +: 8] = sbox(i_word[gi*8 +: 8]);
    end
  endgenerate

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: after load, runs the forward expansion to the
// round-10 key, then walks backwards one round key per accepted adv strobe.
// A single SubWord instance is shared by the forward and inverse steps.
module aes_inv_key_schedule #(
  parameter int NR    = 10,
  parameter int RND_W = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [127:0]     key,
  input  logic             adv,
  output logic [127:0]     rk,
  output logic [RND_W-1:0] round,
  output logic             rk_valid,
  output logic             busy,
  output logic             done
);

  import aes_pkg::*;

  generate
    if (NR != aes_pkg::NR) begin : g_bad_nr
      $error("aes_inv_key_schedule: only NR=10 (AES-128) is supported");
    end
    if (RND_W < 4) begin : g_bad_rnd_w
      $error("aes_inv_key_schedule: RND_W must be at least 4");
    end
  endgenerate

  // State: work key, shared forward-count / round-index register, FSM state.
  ks_state_t   r_state;
  rk_words_t   r_key;
  logic [3:0]  r_cnt;

  logic [31:0] w_inv_w3;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_rot;
  logic [31:0] w_sub_out;
  logic [31:0] w_rcon_word;
  logic [3:0]  w_rcon_idx;
  logic [31:0] w_f0, w_f1, w_f2, w_f3;
  rk_words_t   w_fwd;
  rk_words_t   w_inv;

  // SubWord operand mux: forward uses w3, inverse uses the recovered w3 (w3^w2).
  // Rcon index is the forward count, or round-1 when stepping backwards.
  always_comb begin
    w_inv_w3    = r_key[3] ^ r_key[2];
    w_sub_in    = (r_state == ST_READY) ? w_inv_w3 : r_key[3];
    w_sub_rot   = rot_word(w_sub_in);
    w_rcon_idx  = (r_state == ST_READY) ? (r_cnt - 4'd1) : r_cnt;
    w_rcon_word = {rcon_byte(w_rcon_idx), 24'h000000};
  end

  aes_subword u_subword (
    .i_word (w_sub_rot),
    .o_word (w_sub_out)
  );

  // Next-key candidates for one forward step and one inverse step.
  always_comb begin
    w_f0     = r_key[0] ^ w_sub_out ^ w_rcon_word;
    w_f1     = r_key[1] ^ w_f0;
    w_f2     = r_key[2] ^ w_f1;
    w_f3     = r_key[3] ^ w_f2;
    w_fwd    = {w_f0, w_f1, w_f2, w_f3};
    w_inv[3] = w_inv_w3;
    w_inv[2] = r_key[2] ^ r_key[1];
    w_inv[1] = r_key[1] ^ r_key[0];
    w_inv[0] = r_key[0] ^ w_sub_out ^ w_rcon_word;
  end

  // Controller: reset beats load, load beats everything else and restarts from any state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_state <= ST_FWD;
      r_key   <= key;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_FWD: begin
          r_key <= w_fwd;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(NR - 1)) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (adv) begin
            r_key <= w_inv;
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode directly from state; round reads 0 while the count runs.
  always_comb begin
    rk       = r_key;
    round    = (r_state == ST_FWD) ? '0 : RND_W'(r_cnt);
    rk_valid = (r_state == ST_READY) || (r_state == ST_DONE);
    busy     = (r_state == ST_FWD);
    done     = (r_state == ST_DONE);
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule against a table-driven
// FIPS-197 key expansion model.
module tb_aes_inv_key_schedule;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic         adv = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         rk_valid;
  logic         busy;
  logic         done;

  logic [127:0] e_rk;
  logic [3:0]   e_round;
  logic         e_valid;
  logic         e_busy;
  logic         e_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];

  aes_inv_key_schedule #(.NR(10), .RND_W(4)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .load     (load),
    .key      (key),
    .adv      (adv),
    .rk       (rk),
    .round    (round),
    .rk_valid (rk_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  // Polynomial multiply followed by long-division reduction mod 0x11b.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // S-box table by brute-force inverse search and the FIPS affine map.
  task automatic build_sbox();
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ d[15-k -: 8];
      sb[x] = s;
    end
  endtask

  // FIPS-197 word-oriented key expansion into the eleven round keys.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_zero();
    e_rk = '0; e_round = 4'd0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endtask

  task automatic expect_fwd(input int c);
    e_rk = exp_rk[c]; e_round = 4'd0; e_valid = 1'b0; e_busy = 1'b1; e_done = 1'b0;
  endtask

  task automatic expect_ready(input int r);
    e_rk = exp_rk[r]; e_round = 4'(r); e_valid = 1'b1; e_busy = 1'b0; e_done = (r == 0);
  endtask

  // Load a key (optionally with adv high throughout) and follow the ten forward cycles.
  task automatic load_and_expand(input logic [127:0] k, input logic adv_during);
    expand(k);
    key = k; load = 1'b1; adv = adv_during;
    tick();
    load = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      if (c < 10) expect_fwd(c); else expect_ready(10);
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL fwd_cycle%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want rk=%h round=%0d valid=%b busy=%b done=%b",
                 c, rk, round, rk_valid, busy, done, e_rk, e_round, e_valid, e_busy, e_done);
      end
    end
    adv = 1'b0;
    $display("load key=%h adv=%b -> round %0d rk=%h", k, adv_during, round, rk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      reset = (c < 4);
      load  = (c < 4) ? 1'($urandom) : 1'b0;
      adv   = 1'($urandom);
      key   = rand128();
      tick();
      expect_zero();
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL reset_idle%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want all zero",
                 c, rk, round, rk_valid, busy, done);
      end
    end
    reset = 1'b0; load = 1'b0; adv = 1'b0;
    $display("reset/idle: 8 quiet cycles checked");
  endtask

  task automatic test_fips_load();
    load_and_expand(FIPS_KEY, 1'b0);
    n_checks++;
    if (rk !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++;
      $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk);
    end
  endtask

  // Single adv pulses with idle gaps, then one surplus adv in DONE.
  task automatic test_step_adv();
    int cur;
    logic [127:0] want;
    cur = 10;
    for (int r = 9; r >= -1; r--) begin
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        tick();
        expect_ready(cur);
        n_checks++;
        if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
          n_fail++;
          $display("FAIL hold_r%0d: got rk=%h round=%0d valid=%b done=%b, want rk=%h round=%0d valid=%b done=%b",
                   cur, rk, round, rk_valid, done, e_rk, e_round, e_valid, e_done);
        end
      end
      adv = 1'b1;
      tick();
      adv = 1'b0;
      cur = (r < 0) ? 0 : r;
      expect_ready(cur);
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL step_r%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want rk=%h round=%0d valid=%b busy=%b done=%b",
                 r, rk, round, rk_valid, busy, done, e_rk, e_round, e_valid, e_busy, e_done);
      end
      if (r == 9 || r == 1 || r == 0) begin
        want = (r == 9) ? 128'hac7766f319fadc2128d12941575c006e :
               (r == 1) ? 128'ha0fafe1788542cb123a339392a6c7605 : FIPS_KEY;
        n_checks++;
        if (rk !== want) begin
          n_fail++;
          $display("FAIL fips_rk%0d: got %h want %h", r, rk, want);
        end
      end
      $display("adv -> round %0d rk=%h done=%b", round, rk, done);
    end
  endtask

  // adv held high from READY: one key per cycle down to round 0, then held.
  task automatic test_back_to_back(input logic [127:0] k);
    load_and_expand(k, 1'b0);
    adv = 1'b1;
    for (int r = 9; r >= -2; r--) begin
      tick();
      expect_ready((r < 0) ? 0 : r);
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL b2b_r%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want rk=%h round=%0d valid=%b busy=%b done=%b",
                 r, rk, round, rk_valid, busy, done, e_rk, e_round, e_valid, e_busy, e_done);
      end
    end
    adv = 1'b0;
    $display("back-to-back key=%h ended round %0d done=%b", k, round, done);
  endtask

  // Walk to round 5, then load a new key in the same cycle as adv.
  task automatic test_load_override();
    load_and_expand(FIPS_KEY, 1'b0);
    for (int r = 9; r >= 5; r--) begin
      adv = 1'b1;
      tick();
      adv = 1'b0;
      expect_ready(r);
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL ovr_walk_r%0d: got rk=%h round=%0d, want rk=%h round=%0d", r, rk, round, e_rk, e_round);
      end
    end
    load_and_expand(SEQ_KEY, 1'b1);
    n_checks++;
    if ({rk, round} !== {128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd10}) begin
      n_fail++;
      $display("FAIL ovr_rk10: got rk=%h round=%0d want rk=13111d7fe3944a17f307a78b4d2b30c5 round=10", rk, round);
    end
  endtask

  // Reset on the fourth forward cycle discards the partial key; adv afterwards is inert.
  task automatic test_reset_mid_fwd();
    logic [127:0] k;
    k = rand128();
    expand(k);
    key = k; load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      expect_fwd(c);
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL rstmid_fwd%0d: got rk=%h busy=%b, want rk=%h busy=%b", c, rk, busy, e_rk, e_busy);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    adv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      expect_zero();
      n_checks++;
      if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL rstmid_zero%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want all zero",
                 c, rk, round, rk_valid, busy, done);
      end
    end
    adv = 1'b0;
    $display("reset mid-forward key=%h -> outputs cleared", k);
  endtask

  // A second load during the forward run restarts with the new key.
  task automatic test_restart_fwd();
    key = rand128(); load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < $urandom_range(1, 6); c++) tick();
    load_and_expand(rand128(), 1'($urandom));
  endtask

  // Random keys and random adv patterns tracked by a round counter model.
  task automatic test_random();
    int cur;
    logic a;
    for (int n = 0; n < 5; n++) begin
      load_and_expand(rand128(), 1'($urandom));
      cur = 10;
      for (int c = 0; c < 16; c++) begin
        a = ($urandom_range(0, 3) != 0);
        adv = a;
        tick();
        if (a && cur > 0) cur--;
        expect_ready(cur);
        n_checks++;
        if ({rk, round, rk_valid, busy, done} !== {e_rk, e_round, e_valid, e_busy, e_done}) begin
          n_fail++;
          $display("FAIL rand%0d_c%0d: got rk=%h round=%0d valid=%b busy=%b done=%b, want rk=%h round=%0d valid=%b busy=%b done=%b",
                   n, c, rk, round, rk_valid, busy, done, e_rk, e_round, e_valid, e_busy, e_done);
        end
      end
      adv = 1'b0;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_load();
    test_step_adv();
    test_back_to_back(FIPS_KEY);
    test_back_to_back(rand128());
    test_load_override();
    test_reset_mid_fwd();
    test_restart_fwd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
